timer_csr_frontend: RTL and testbench
=====================================

// Module: timer_csr_frontend
// PURPOSE
//  Software-facing register frontend driving timer_core. Holds the timer CSRs
//  (control, prescaler/step, 64-bit mtime, N 64-bit mtimecmp), advances mtime on
//  each core tick, and converts the core's level compare outputs into sticky,
//  maskable interrupts. Sits between the peripheral bus and timer_core.
// PARAMETERS
//  N   1   number of harts/comparators (1..8); one mtimecmp and one intr bit each
// PORTS
//  clk_i         in   1      clock
//  rst_ni        in   1      synchronous active-low reset
//  req_i         in   1      bus request; always accepted, no stall
//  we_i          in   1      1=write, 0=read
//  addr_i        in   8      byte address, word aligned ([1:0] ignored)
//  wdata_i       in   32     write data
//  rvalid_o      out  1      response valid, one cycle after req_i
//  rdata_o       out  32     read data, valid with rvalid_o (0 for writes/errors)
//  rerror_o      out  1      unmapped address, valid with rvalid_o
//  active_o      out  1      to core: CTRL[0]
//  prescaler_o   out  12     to core: CFG[11:0]
//  step_o        out  8      to core: CFG[23:16]
//  mtime_o       out  64     to core: current mtime register
//  mtimecmp_o    out  64*N   to core: hart i at [64*i +: 64]
//  tick_i        in   1      from core: advance mtime this cycle
//  mtime_d_i     in   64     from core: mtime + step
//  intr_raw_i    in   N      from core: level, mtime >= mtimecmp[i] and active
//  intr_o        out  N      intr_state & intr_enable
// BEHAVIOUR
//  Map: 0x00 CTRL[0]; 0x04 CFG{step[23:16],prescaler[11:0]}; 0x08 MTIME_LO;
//   0x0C MTIME_HI; 0x10 INTR_ENABLE[N-1:0]; 0x14 INTR_STATE (RO/W1C);
//   0x18 INTR_TEST (WO, reads 0); 0x20+8i MTIMECMP_LO[i], 0x24+8i MTIMECMP_HI[i].
//   Unused bits read 0, write-ignored. Any other address (incl. cmp i>=N): error.
//  Reset (rst_ni=0 at edge): CTRL,CFG,mtime,enable,state=0; all mtimecmp=64'hFFFF_FFFF_FFFF_FFFF;
//   rvalid_o=0, rdata_o=0, rerror_o=0, intr_o=0. Reset mid-transaction drops response.
//  Bus: req_i sampled at edge k -> rvalid_o=1 at k+1 with registered rdata/rerror;
//   back-to-back requests give back-to-back responses. Write updates register at
//   edge k; new value visible on core outputs in cycle k+1. Read returns value
//   held before edge k (read-before-same-cycle hardware update).
//  Errors: write ignored, rdata_o=0, rerror_o=1 for that one response.
//  mtime: SW write to LO or HI replaces only that half; priority SW write > tick.
//   Else tick_i=1 -> mtime <= mtime_d_i (wraps at 2^64, as supplied by core).
//   Halves are independent; no shadowing (software handles LO/HI tearing).
//  mtimecmp: per-half writes, no hardware side effects beyond new compare.
//  INTR_STATE[i]: set when intr_raw_i[i]=1 or INTR_TEST write with bit i=1;
//   cleared by W1C write with bit i=1; set wins over clear in the same cycle.
//   While intr_raw_i[i] stays high the bit re-sets every cycle (clear ineffective).
//  intr_o registered from state&enable combinationally: intr_o = state & enable.
//  CTRL.active=0 does not clear state or mtime; core stops ticking.
// TESTING
//  1 Reset: after rst_ni low 2 cycles -> all outputs 0, read 0x20 = 0xFFFFFFFF.
//  2 Write CFG=0x0003_0002, CTRL=1, tick_i pulses with mtime_d_i=mtime+3 ->
//    mtime_o 0,3,6; read 0x08 returns 6 one cycle after req.
//  3 tick_i=1 and SW write MTIME_LO=0x100 same cycle -> mtime_o[31:0]=0x100,
//    upper half keeps prior value (SW wins).
//  4 intr_raw_i[0]=1 one cycle, enable=0 -> INTR_STATE=1, intr_o=0; write
//    enable=1 -> intr_o[0]=1; W1C 0x14=1 with raw low -> intr_o=0 next cycle.
//  5 W1C and intr_raw_i[0]=1 same cycle -> state stays 1; INTR_TEST=1 sets it.
//  6 N=2: read 0x30 -> rerror_o=1, rdata_o=0; write 0x30 alters no register;
//    read-write-read back-to-back -> three consecutive rvalid_o pulses.

Source files
------------

// File: rtl/timer_csr_frontend_if.sv
// Peripheral bus bundle for the timer CSR frontend.
// Single-cycle request, registered response one cycle later.
interface timer_csr_frontend_if;
    logic        req_i;
    logic        we_i;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        rerror_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rvalid_o, rdata_o, rerror_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rvalid_o, rdata_o, rerror_o
    );
endinterface

// File: rtl/timer_csr_frontend.sv
// Timer CSR frontend: control/config, 64-bit mtime, per-hart mtimecmp,
// sticky maskable interrupts fed from the core's level compare outputs.
module timer_csr_frontend #(
    parameter int unsigned N = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    timer_csr_frontend_if.slave bus,
    output logic               active_o,
    output logic [11:0]        prescaler_o,
    output logic [7:0]         step_o,
    output logic [63:0]        mtime_o,
    output logic [64*N-1:0]    mtimecmp_o,
    input  logic               tick_i,
    input  logic [63:0]        mtime_d_i,
    input  logic [N-1:0]       intr_raw_i,
    output logic [N-1:0]       intr_o
);

    logic          ctrl_q;
    logic [11:0]   prescaler_q;
    logic [7:0]    step_q;
    logic [63:0]   mtime_q;
    logic [N-1:0]  en_q;
    logic [N-1:0]  state_q;
    logic [63:0]   cmp_q [N];

    logic          rvalid_q;
    logic [31:0]   rdata_q;
    logic          rerror_q;

    logic [5:0]    wa;
    logic          known;
    logic          err;
    logic          wr;
    logic [N-1:0]  cmp_lo_hit;
    logic [N-1:0]  cmp_hi_hit;
    logic [31:0]   rd;
    logic [N-1:0]  w1c_mask;
    logic [N-1:0]  test_mask;
    logic [N-1:0]  state_d;

    assign wa = bus.addr_i[7:2];

    always_comb begin
        cmp_lo_hit = '0;
        cmp_hi_hit = '0;
        for (int i = 0; i < int'(N); i++) begin
            cmp_lo_hit[i] = (wa == 6'(8 + 2 * i));
            cmp_hi_hit[i] = (wa == 6'(9 + 2 * i));
        end
    end

    assign known = (wa <= 6'd6);
    assign err = !(known || (|cmp_lo_hit) || (|cmp_hi_hit));
    assign wr = bus.req_i && bus.we_i && !err;

    always_comb begin
        rd = '0;
        case (wa)
            6'd0: rd = {31'b0, ctrl_q};
            6'd1: rd = {8'b0, step_q, 4'b0, prescaler_q};
            6'd2: rd = mtime_q[31:0];
            6'd3: rd = mtime_q[63:32];
            6'd4: rd[N-1:0] = en_q;
            6'd5: rd[N-1:0] = state_q;
            default: ;
        endcase
        for (int i = 0; i < int'(N); i++) begin
            if (cmp_lo_hit[i]) rd = cmp_q[i][31:0];
            if (cmp_hi_hit[i]) rd = cmp_q[i][63:32];
        end
    end

    // Hardware set wins over a W1C clear landing in the same cycle.
    assign w1c_mask  = (wr && wa == 6'd5) ? bus.wdata_i[N-1:0] : '0;
    assign test_mask = (wr && wa == 6'd6) ? bus.wdata_i[N-1:0] : '0;
    assign state_d   = (state_q & ~w1c_mask) | intr_raw_i | test_mask;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ctrl_q      <= 1'b0;
            prescaler_q <= '0;
            step_q      <= '0;
            mtime_q     <= '0;
            en_q        <= '0;
            state_q     <= '0;
            for (int i = 0; i < int'(N); i++) begin
                cmp_q[i] <= '1;
            end
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rerror_q    <= 1'b0;
        end else begin
            if (wr && wa == 6'd0) ctrl_q <= bus.wdata_i[0];
            if (wr && wa == 6'd1) begin
                prescaler_q <= bus.wdata_i[11:0];
                step_q      <= bus.wdata_i[23:16];
            end
            if (wr && wa == 6'd4) en_q <= bus.wdata_i[N-1:0];
            state_q <= state_d;

            // A software write to either half suppresses the tick entirely.
            if (wr && wa == 6'd2) begin
                mtime_q[31:0] <= bus.wdata_i;
            end else if (wr && wa == 6'd3) begin
                mtime_q[63:32] <= bus.wdata_i;
            end else if (tick_i) begin
                mtime_q <= mtime_d_i;
            end

            for (int i = 0; i < int'(N); i++) begin
                if (wr && cmp_lo_hit[i]) cmp_q[i][31:0]  <= bus.wdata_i;
                if (wr && cmp_hi_hit[i]) cmp_q[i][63:32] <= bus.wdata_i;
            end

            rvalid_q <= bus.req_i;
            rerror_q <= bus.req_i && err;
            rdata_q  <= (bus.req_i && !bus.we_i && !err) ? rd : 32'h0;
        end
    end

    always_comb begin
        mtimecmp_o = '0;
        for (int i = 0; i < int'(N); i++) begin
            mtimecmp_o[64*i +: 64] = cmp_q[i];
        end
    end

    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.rerror_o = rerror_q;
    assign active_o     = ctrl_q;
    assign prescaler_o  = prescaler_q;
    assign step_o       = step_q;
    assign mtime_o      = mtime_q;
    assign intr_o       = state_q & en_q;

endmodule

// File: tb/tb_timer_csr_frontend.sv
// Directed bench for timer_csr_frontend with two harts.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_timer_csr_frontend;
    localparam int unsigned N = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            active_o;
    logic [11:0]     prescaler_o;
    logic [7:0]      step_o;
    logic [63:0]     mtime_o;
    logic [64*N-1:0] mtimecmp_o;
    logic            tick_i;
    logic [63:0]     mtime_d_i;
    logic [N-1:0]    intr_raw_i;
    logic [N-1:0]    intr_o;

    int checks = 0;
    int failures = 0;

    timer_csr_frontend_if bus ();

    timer_csr_frontend #(.N(N)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bus         (bus.slave),
        .active_o    (active_o),
        .prescaler_o (prescaler_o),
        .step_o      (step_o),
        .mtime_o     (mtime_o),
        .mtimecmp_o  (mtimecmp_o),
        .tick_i      (tick_i),
        .mtime_d_i   (mtime_d_i),
        .intr_raw_i  (intr_raw_i),
        .intr_o      (intr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic we, input logic [7:0] a,
                       input logic [31:0] d);
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.addr_i  = a;
        bus.wdata_i = d;
    endtask

    task automatic idle();
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = 8'h00;
        bus.wdata_i = 32'h0;
    endtask

    initial begin
        rst_ni     = 1'b0;
        tick_i     = 1'b0;
        mtime_d_i  = '0;
        intr_raw_i = '0;
        idle();
        #1;
        step();
        step();
        chk("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
        chk("rst_rdata", 64'(bus.rdata_o), 64'd0);
        chk("rst_rerror", 64'(bus.rerror_o), 64'd0);
        chk("rst_active", 64'(active_o), 64'd0);
        chk("rst_cfg", {44'd0, step_o, prescaler_o}, 64'd0);
        chk("rst_mtime", mtime_o, 64'd0);
        chk("rst_cmp0", mtimecmp_o[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_cmp1", mtimecmp_o[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_intr", 64'(intr_o), 64'd0);

        rst_ni = 1'b1;
        req(1'b0, 8'h20, 32'h0);
        step();
        chk("rd20_valid", 64'(bus.rvalid_o), 64'd1);
        chk("rd20_data", 64'(bus.rdata_o), 64'hFFFF_FFFF);
        chk("rd20_err", 64'(bus.rerror_o), 64'd0);
        idle();
        step();
        chk("idle_valid", 64'(bus.rvalid_o), 64'd0);

        req(1'b1, 8'h04, 32'h0003_0002);
        step();
        chk("cfg_pre", 64'(prescaler_o), 64'd2);
        chk("cfg_step", 64'(step_o), 64'd3);
        chk("wr_rdata", 64'(bus.rdata_o), 64'd0);
        req(1'b1, 8'h00, 32'h1);
        step();
        chk("ctrl_act", 64'(active_o), 64'd1);
        idle();
        chk("mtime_0", mtime_o, 64'd0);
        tick_i = 1'b1;
        mtime_d_i = 64'd3;
        step();
        chk("mtime_3", mtime_o, 64'd3);
        mtime_d_i = 64'd6;
        step();
        chk("mtime_6", mtime_o, 64'd6);
        tick_i = 1'b0;
        req(1'b0, 8'h08, 32'h0);
        step();
        chk("rd_mtlo", 64'(bus.rdata_o), 64'd6);

        req(1'b1, 8'h0C, 32'h0000_ABCD);
        step();
        chk("mt_hi_wr", mtime_o, 64'h0000_ABCD_0000_0006);
        req(1'b1, 8'h08, 32'h0000_0100);
        tick_i = 1'b1;
        mtime_d_i = 64'h1234_5678_9ABC_DEF0;
        step();
        chk("sw_wins", mtime_o, 64'h0000_ABCD_0000_0100);
        idle();
        mtime_d_i = 64'h0000_0001_0000_0000;
        step();
        chk("tick_load", mtime_o, 64'h0000_0001_0000_0000);
        tick_i = 1'b0;

        intr_raw_i = 2'b01;
        step();
        intr_raw_i = 2'b00;
        chk("intr_mask", 64'(intr_o), 64'd0);
        req(1'b0, 8'h14, 32'h0);
        step();
        chk("st_sticky", 64'(bus.rdata_o), 64'd1);
        req(1'b1, 8'h10, 32'h1);
        step();
        chk("intr_en", 64'(intr_o), 64'd1);
        req(1'b1, 8'h14, 32'h1);
        step();
        chk("w1c_clr", 64'(intr_o), 64'd0);

        req(1'b1, 8'h14, 32'h1);
        intr_raw_i = 2'b01;
        step();
        intr_raw_i = 2'b00;
        chk("set_wins", 64'(intr_o), 64'd1);
        req(1'b1, 8'h14, 32'h1);
        step();
        chk("w1c_clr2", 64'(intr_o), 64'd0);
        req(1'b1, 8'h18, 32'h3);
        step();
        chk("test_set", 64'(intr_o), 64'd1);
        req(1'b0, 8'h14, 32'h0);
        step();
        chk("test_st", 64'(bus.rdata_o), 64'd3);
        req(1'b0, 8'h18, 32'h0);
        step();
        chk("test_rd0", 64'(bus.rdata_o), 64'd0);

        req(1'b1, 8'h20, 32'h0000_0055);
        step();
        chk("cmp0_lo", mtimecmp_o[63:0], 64'hFFFF_FFFF_0000_0055);
        req(1'b0, 8'h30, 32'h0);
        step();
        chk("e_rd_err", 64'(bus.rerror_o), 64'd1);
        chk("e_rd_dat", 64'(bus.rdata_o), 64'd0);
        req(1'b1, 8'h30, 32'hDEAD_BEEF);
        step();
        chk("e_wr_err", 64'(bus.rerror_o), 64'd1);
        chk("e_cmp0", mtimecmp_o[63:0], 64'hFFFF_FFFF_0000_0055);
        chk("e_cmp1", mtimecmp_o[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("e_mtime", mtime_o, 64'h0000_0001_0000_0000);
        req(1'b0, 8'h1C, 32'h0);
        step();
        chk("e_1c", 64'(bus.rerror_o), 64'd1);

        req(1'b0, 8'h28, 32'h0);
        step();
        chk("b2b_v0", 64'(bus.rvalid_o), 64'd1);
        chk("b2b_d0", 64'(bus.rdata_o), 64'hFFFF_FFFF);
        chk("b2b_e0", 64'(bus.rerror_o), 64'd0);
        req(1'b1, 8'h2C, 32'h0000_0001);
        step();
        chk("b2b_v1", 64'(bus.rvalid_o), 64'd1);
        chk("b2b_d1", 64'(bus.rdata_o), 64'd0);
        req(1'b0, 8'h2C, 32'h0);
        step();
        chk("b2b_v2", 64'(bus.rvalid_o), 64'd1);
        chk("b2b_d2", 64'(bus.rdata_o), 64'd1);
        chk("cmp1_hi", mtimecmp_o[127:64], 64'h0000_0001_FFFF_FFFF);

        req(1'b0, 8'h00, 32'h0);
        rst_ni = 1'b0;
        step();
        chk("rst_drop", 64'(bus.rvalid_o), 64'd0);
        chk("rst_intr2", 64'(intr_o), 64'd0);
        chk("rst_cmp1b", mtimecmp_o[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
